// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding, fetch region
// codes, default address map and the address-region decoder.
package fetch_pkg;

  // FSM state codes as seen on the state output
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Which backing store answered a fetch
  typedef enum logic [1:0] {
    RGN_ROM  = 2'd0,
    RGN_RAM  = 2'd1,
    RGN_IO   = 2'd2,
    RGN_NONE = 2'd3
  } region_e;

  // Default address map
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_ROM_TOP  = 'h7F;
  localparam int DEF_RAM_BASE = 'h80;
  localparam int DEF_RAM_TOP  = 'hDF;
  localparam int DEF_IO_BASE  = 'hF0;
  localparam int DEF_N_PORTS  = 16;

  // Map an address onto a region; ROM starts at address 0.
  function automatic region_e decode_region(
    input int addr,
    input int rom_top,
    input int ram_base,
    input int ram_top,
    input int io_base,
    input int n_ports
  );
    if (addr <= rom_top)
      return RGN_ROM;
    else if (addr >= ram_base && addr <= ram_top)
      return RGN_RAM;
    else if (addr >= io_base && addr < io_base + n_ports)
      return RGN_IO;
    else
      return RGN_NONE;
  endfunction

endpackage

// File: rtl/fetch_sync_ram.sv
// Single-port-write, single-port-read synchronous RAM. The read is
// registered and read-first: a read and a write to the same word in one
// cycle return the word's previous contents. Contents have no reset.
module fetch_sync_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; holds its last word while i_re is low
  always_ff @(posedge clk) begin
    if (i_re)
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fetch_unit.sv
// Program-counter driven fetch unit with a LOAD/RUN/HALT controller.
// Fetches come from ROM, RAM, memory-mapped input ports, or an unmapped
// hole (which returns zero with bus_err). Every region has one cycle of
// latency: the result appears on the clock edge that ends the issue cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ROM_TOP  = DEF_ROM_TOP,
  parameter int RAM_BASE = DEF_RAM_BASE,
  parameter int RAM_TOP  = DEF_RAM_TOP,
  parameter int IO_BASE  = DEF_IO_BASE,
  parameter int N_PORTS  = DEF_N_PORTS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      halt,
  input  logic                      stall,
  input  logic                      jump_en,
  input  logic [ADDR_W-1:0]         jump_addr,
  input  logic                      prog_we,
  input  logic [ADDR_W-1:0]         prog_addr,
  input  logic [DATA_W-1:0]         prog_data,
  input  logic                      mem_we,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_wdata,
  input  logic [N_PORTS*DATA_W-1:0] port_in,
  output logic [ADDR_W-1:0]         pc,
  output logic [DATA_W-1:0]         data_out,
  output logic [ADDR_W-1:0]         fetch_addr,
  output logic                      data_valid,
  output logic                      bus_err,
  output logic                      wr_err,
  output logic [1:0]                state
);

  localparam int ROM_DEPTH = ROM_TOP + 1;
  localparam int ROM_AW    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int RAM_DEPTH = RAM_TOP - RAM_BASE + 1;
  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  // Registered state
  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_fetch_addr;
  region_e           r_sel;
  logic [DATA_W-1:0] r_io_data;
  logic              r_valid;
  logic              r_bus_err;
  logic              r_wr_err;

  // Combinational helpers
  logic              w_issue;
  region_e           w_region;
  logic              w_prog_in_rom;
  logic              w_mem_in_ram;
  logic              w_rom_we;
  logic              w_ram_we;
  logic              w_prog_rej;
  logic              w_mem_rej;
  logic [ADDR_W-1:0] w_io_off;
  logic [DATA_W-1:0] w_io_word;
  logic [DATA_W-1:0] w_rom_rdata;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_ports [N_PORTS];

  // Fetch issue and region decode of the current pc
  assign w_issue  = !rst && (r_state == ST_RUN) && !stall;
  assign w_region = decode_region(int'(r_pc), ROM_TOP, RAM_BASE, RAM_TOP,
                                  IO_BASE, N_PORTS);

  // Write-port qualification; prog_we only counts while loading
  assign w_prog_in_rom = (int'(prog_addr) <= ROM_TOP);
  assign w_mem_in_ram  = (int'(mem_addr) >= RAM_BASE) && (int'(mem_addr) <= RAM_TOP);
  assign w_rom_we      = !rst && (r_state == ST_LOAD) && prog_we && w_prog_in_rom;
  assign w_ram_we      = !rst && mem_we && w_mem_in_ram;
  assign w_prog_rej    = (r_state == ST_LOAD) && prog_we && !w_prog_in_rom;
  assign w_mem_rej     = mem_we && !w_mem_in_ram;

  // Unflatten the input-port bus
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign w_ports[gi] = port_in[gi*DATA_W +: DATA_W];
  end

  assign w_io_off = r_pc - ADDR_W'(IO_BASE);

  // Select the input port addressed by pc
  always_comb begin
    w_io_word = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (w_io_off == ADDR_W'(k))
        w_io_word = w_ports[k];
    end
  end

  fetch_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (ROM_DEPTH),
    .AW     (ROM_AW)
  ) u_rom (
    .clk     (clk),
    .i_we    (w_rom_we),
    .i_waddr (ROM_AW'(prog_addr)),
    .i_wdata (prog_data),
    .i_re    (w_issue && (w_region == RGN_ROM)),
    .i_raddr (ROM_AW'(r_pc)),
    .o_rdata (w_rom_rdata)
  );

  fetch_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (RAM_AW'(mem_addr - ADDR_W'(RAM_BASE))),
    .i_wdata (mem_wdata),
    .i_re    (w_issue && (w_region == RGN_RAM)),
    .i_raddr (RAM_AW'(r_pc - ADDR_W'(RAM_BASE))),
    .o_rdata (w_ram_rdata)
  );

  // Controller: halt wins over start while running
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (start) r_state <= ST_RUN;
        ST_RUN:  if (halt)  r_state <= ST_HALT;
        ST_HALT: if (start) r_state <= ST_RUN;
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // PC advance, fetch bookkeeping and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= '0;
      r_fetch_addr <= '0;
      r_sel        <= RGN_NONE;
      r_io_data    <= '0;
      r_valid      <= 1'b0;
      r_bus_err    <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_wr_err  <= w_prog_rej | w_mem_rej;
      r_valid   <= w_issue;
      r_bus_err <= w_issue && (w_region == RGN_NONE);
      if (w_issue) begin
        r_fetch_addr <= r_pc;
        r_sel        <= w_region;
        if (w_region == RGN_IO)
          r_io_data <= w_io_word;
        r_pc <= jump_en ? jump_addr : r_pc + ADDR_W'(1);
      end
    end
  end

  // Result mux over registered sources. The RAM read registers only load on
  // an issue, and r_sel resets to NONE, so data_out holds while idle and
  // reads zero after reset without having to reset the memory outputs.
  always_comb begin
    data_out = '0;
    case (r_sel)
      RGN_ROM:  data_out = w_rom_rdata;
      RGN_RAM:  data_out = w_ram_rdata;
      RGN_IO:   data_out = r_io_data;
      default:  data_out = '0;
    endcase
  end

  assign pc         = r_pc;
  assign fetch_addr = r_fetch_addr;
  assign data_valid = r_valid;
  assign bus_err    = r_bus_err;
  assign wr_err     = r_wr_err;
  assign state      = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model predicts every
// fetch, pushes it to a scoreboard queue at issue, and pops it when the
// DUT raises data_valid. Table vectors cover the address map; short
// hand-written sequences cover wrap, stall, halt and reset.
module tb_fetch_unit;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NP = 16;

  logic clk = 1'b0;
  logic rst, start, halt, stall, jump_en;
  logic [AW-1:0] jump_addr;
  logic prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [NP*DW-1:0] port_in;
  logic [AW-1:0] pc, fetch_addr;
  logic [DW-1:0] data_out;
  logic data_valid, bus_err, wr_err;
  logic [1:0] state;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_W(DW), .ADDR_W(AW), .ROM_TOP('h7F), .RAM_BASE('h80),
    .RAM_TOP('hDF), .IO_BASE('hF0), .N_PORTS(NP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .stall(stall),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .port_in(port_in), .pc(pc), .data_out(data_out), .fetch_addr(fetch_addr),
    .data_valid(data_valid), .bus_err(bus_err), .wr_err(wr_err), .state(state)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       berr;
  } fetch_t;

  typedef struct {
    logic [7:0] jaddr;
    logic [7:0] exp_data;
    logic       exp_berr;
  } vec_t;

  fetch_t sb_q[$];
  int total = 0;
  int bad = 0;

  // Reference model
  logic [7:0] rom_m [128];
  logic [7:0] ram_m [96];
  int         m_state;
  logic [7:0] m_pc, m_dout, m_faddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_word(input logic [7:0] a);
    int ia;
    ia = int'(a);
    if (ia <= 'h7F) return {1'b0, rom_m[ia]};
    if (ia >= 'h80 && ia <= 'hDF) return {1'b0, ram_m[ia - 'h80]};
    if (ia >= 'hF0) return {1'b0, port_in[(ia - 'hF0)*8 +: 8]};
    return {1'b1, 8'h00};
  endfunction

  // One clock: predict, advance the model, clock the DUT, compare
  task automatic step();
    bit issue, exp_wr, ram_ok;
    fetch_t e;
    ram_ok = (mem_addr >= 8'h80) && (mem_addr <= 8'hDF);
    issue  = !rst && (m_state == 1) && !stall;
    exp_wr = !rst && (((m_state == 0) && prog_we && (prog_addr > 8'h7F)) || (mem_we && !ram_ok));
    if (issue) begin
      e.addr = m_pc;
      {e.berr, e.data} = exp_word(m_pc);
      sb_q.push_back(e);
    end
    if (rst) begin
      m_state = 0; m_pc = 8'h00; m_dout = 8'h00; m_faddr = 8'h00;
    end else begin
      if ((m_state == 0) && prog_we && (prog_addr <= 8'h7F)) rom_m[int'(prog_addr)] = prog_data;
      if (mem_we && ram_ok) ram_m[int'(mem_addr) - 'h80] = mem_wdata;
      if (issue) m_pc = jump_en ? jump_addr : m_pc + 8'd1;
      case (m_state)
        0: if (start) m_state = 1;
        1: if (halt) m_state = 2;
        2: if (start) m_state = 1;
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    chk("state", state, m_state);
    chk("pc", pc, m_pc);
    chk("data_valid", data_valid, issue);
    chk("wr_err", wr_err, exp_wr);
    if (data_valid) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got data_valid=1 with data %0h expected no fetch", data_out);
      end else begin
        e = sb_q.pop_front();
        m_dout = e.data; m_faddr = e.addr;
        chk("sb_data", data_out, e.data);
        chk("sb_addr", fetch_addr, e.addr);
        chk("sb_berr", bus_err, e.berr);
      end
    end else begin
      chk("hold_data", data_out, m_dout);
      chk("hold_addr", fetch_addr, m_faddr);
      chk("idle_berr", bus_err, 1'b0);
    end
  endtask

  task automatic idle();
    start = 0; halt = 0; stall = 0; jump_en = 0; prog_we = 0; mem_we = 0; rst = 0;
  endtask

  task automatic jump(input logic [7:0] a);
    jump_en = 1; jump_addr = a; step(); jump_en = 0;
  endtask

  initial begin
    vec_t vt [12];
    logic [7:0] first4 [4];
    logic [7:0] held_pc;

    first4[0] = 8'h11; first4[1] = 8'h22; first4[2] = 8'h33; first4[3] = 8'h44;
    vt[0]  = '{8'h85, 8'h5A, 1'b0};
    vt[1]  = '{8'hF3, 8'hC3, 1'b0};
    vt[2]  = '{8'hE4, 8'h00, 1'b1};
    vt[3]  = '{8'h10, 8'hB5, 1'b0};   // untouched by the rejected mem_we
    vt[4]  = '{8'h05, 8'hA0, 1'b0};   // untouched by prog_we in RUN
    vt[5]  = '{8'h7F, 8'h77, 1'b0};   // ROM top
    vt[6]  = '{8'h80, 8'hBC, 1'b0};   // RAM base
    vt[7]  = '{8'hDF, 8'hE3, 1'b0};   // RAM top
    vt[8]  = '{8'hE0, 8'h00, 1'b1};   // first hole address
    vt[9]  = '{8'hEF, 8'h00, 1'b1};   // last hole address
    vt[10] = '{8'hF0, 8'hC0, 1'b0};   // first port
    vt[11] = '{8'h00, 8'h11, 1'b0};

    idle();
    jump_addr = 0; prog_addr = 0; prog_data = 0; mem_addr = 0; mem_wdata = 0;
    for (int k = 0; k < NP; k++) port_in[k*8 +: 8] = 8'hC0 + 8'(k);
    m_state = 0; m_pc = 0; m_dout = 0; m_faddr = 0;

    // Reset
    rst = 1; step(); step();
    chk("rst_state", state, 2'd0);
    chk("rst_data", data_out, 8'h00);
    rst = 0;

    // Load ROM
    for (int a = 0; a < 128; a++) begin
      prog_we = 1; prog_addr = 8'(a);
      prog_data = (a < 4) ? first4[a] : ((a == 'h7F) ? 8'h77 : (8'(a) ^ 8'hA5));
      step();
    end
    // Both write ports rejected together -> one pulse
    prog_we = 1; prog_addr = 8'h80; prog_data = 8'hEE;
    mem_we = 1; mem_addr = 8'hE0; mem_wdata = 8'hEE;
    step();
    chk("dual_rej_pulse", wr_err, 1'b1);
    idle(); step();
    chk("dual_rej_single", wr_err, 1'b0);

    // Load RAM (writes allowed in LOAD)
    for (int a = 'h80; a <= 'hDF; a++) begin
      mem_we = 1; mem_addr = 8'(a);
      mem_wdata = (a == 'h85) ? 8'h5A : (8'(a) ^ 8'h3C);
      step();
    end
    idle();

    // Start and boot fetch
    start = 1; step(); start = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("boot_data", data_out, first4[i]);
      chk("boot_addr", fetch_addr, 8'(i));
      chk("boot_valid", data_valid, 1'b1);
    end

    // Writes while running
    mem_we = 1; mem_addr = 8'h10; mem_wdata = 8'hEE; step(); mem_we = 0;
    chk("mem_rej", wr_err, 1'b1);
    prog_we = 1; prog_addr = 8'h05; prog_data = 8'hEE; step();
    prog_addr = 8'h90; step(); prog_we = 0;
    chk("prog_run_ignored", wr_err, 1'b0);

    // Address-map table
    foreach (vt[i]) begin
      jump(vt[i].jaddr);
      step();
      chk("tbl_data", data_out, vt[i].exp_data);
      chk("tbl_addr", fetch_addr, vt[i].jaddr);
      chk("tbl_berr", bus_err, vt[i].exp_berr);
    end

    // Read-first on same-address RAM fetch/write
    jump(8'h85);
    mem_we = 1; mem_addr = 8'h85; mem_wdata = 8'h99; step(); mem_we = 0;
    chk("read_first_old", data_out, 8'h5A);
    jump(8'h85); step();
    chk("read_first_new", data_out, 8'h99);

    // Wrap from FF to 00
    jump(8'hFF); step();
    chk("wrap_ff_addr", fetch_addr, 8'hFF);
    chk("wrap_ff_data", data_out, 8'hCF);
    step();
    chk("wrap_00_addr", fetch_addr, 8'h00);
    chk("wrap_00_data", data_out, 8'h11);

    // Stall three cycles, jump ignored while stalled
    held_pc = m_pc;
    stall = 1; step();
    jump_en = 1; jump_addr = 8'h40; step(); jump_en = 0;
    step();
    chk("stall_pc", pc, held_pc);
    chk("stall_valid", data_valid, 1'b0);
    chk("stall_data", data_out, 8'h11);
    stall = 0; step();
    chk("unstall_addr", fetch_addr, held_pc);

    // Halt, idle, resume at the held pc
    halt = 1; step(); halt = 0;
    held_pc = m_pc;
    step(); step();
    chk("halt_state", state, 2'd2);
    start = 1; step(); start = 0;
    step();
    chk("resume_addr", fetch_addr, held_pc);

    // start and halt together while running -> HALT
    start = 1; halt = 1; step(); idle();
    chk("halt_prio", state, 2'd2);
    start = 1; step(); start = 0;
    step(); step();

    // Reset mid-run; ROM contents survive
    rst = 1; step(); rst = 0;
    chk("rst_mid_state", state, 2'd0);
    chk("rst_mid_data", data_out, 8'h00);
    chk("rst_mid_valid", data_valid, 1'b0);
    start = 1; step(); start = 0;
    step();
    chk("rom_retained", data_out, 8'h11);
    step();
    chk("rom_retained2", data_out, 8'h22);

    idle(); halt = 1; step(); halt = 0; step();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending fetches expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
